// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
//   Bundle between the raster timing generator and its consumers (pixel
//   pipeline, VGA pin drivers).
//
//   Parameters
//     CW       coordinate width of x / y
//     FRAME_W  width of frame_cnt (present only with VGA_TIMING_FRAME_CNT_EN)
//
//   Signals
//     en           consumer -> generator  1 = run, 0 = freeze timing
//     p_tick       generator -> consumer  pixel strobe, aligned with the rest
//     hsync/vsync  generator -> consumer  sync pins, polarity set by generator
//     de           generator -> consumer  visible-area flag
//     x / y        generator -> consumer  current pixel coordinate
//     line_start   generator -> consumer  strobe on the first pixel of a line
//     frame_start  generator -> consumer  strobe on pixel (0,0)
//     frame_cnt    generator -> consumer  frames started (optional)
//
//   Modports
//     master  the timing generator
//     slave   a consumer of the timing
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
// -----------------------------------------------------------------------------
interface vga_timing_if #(
  parameter int CW      = 10,
  parameter int FRAME_W = 16
);

  logic          en;
  logic          p_tick;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;
`endif

  // Elaboration-time sanity checks on the bundle geometry.
  if (CW < 1) begin : g_bad_cw
    $error("vga_timing_if: CW must be >= 1");
  end
  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("vga_timing_if: FRAME_W must be >= 1");
  end

  modport master (
    input  en,
    output p_tick, hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en,
    input  p_tick, hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface : vga_timing_if

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. A programmable divider derives a
//   pixel tick from clk; on each tick the horizontal / vertical counters step
//   through active, front porch, sync and back porch. Every output is
//   registered from a single decode of (h_cnt, v_cnt, tick), so x, y, de,
//   hsync, vsync and the strobes change together, exactly one clk after the
//   counter state they describe, and only on a clk edge that captures a tick.
//
//   Ports
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     vga    master modport of vga_timing_if:
//              en (in) run/freeze; p_tick, hsync, vsync, de, x, y,
//              line_start, frame_start (out); frame_cnt (out, optional)
//
//   Parameters
//     H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal geometry in pixel ticks
//     V_ACTIVE/V_FP/V_SYNC/V_BP  vertical geometry in lines
//     CLK_DIV                    clk cycles per pixel tick (>= 1)
//     HSYNC_POL/VSYNC_POL        asserted level of the sync outputs
//     CW                         coordinate width; totals must fit 2**CW
//     FRAME_W                    frame_cnt width (optional feature only)
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//     Defined   : frame_cnt counts frame_start pulses, wrapping at 2**FRAME_W.
//     Undefined : frame_cnt and its logic are absent.
//
//   The interface instance must be built with the same CW / FRAME_W as this
//   module.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide-by-1 still needs a 1-bit register to keep the code uniform.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  // Elaboration-time guards: a bad geometry would otherwise wrap silently.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL / V_TOTAL do not fit in CW bits");
  end
  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_geom
    $error("vga_timing_gen: active and sync widths must be >= 1");
  end
  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q,   div_d;
  logic [CW-1:0]    h_cnt_q, h_cnt_d;
  logic [CW-1:0]    v_cnt_q, v_cnt_d;

  logic             p_tick_q,      p_tick_d;
  logic             hsync_q,       hsync_d;
  logic             vsync_q,       vsync_d;
  logic             de_q,          de_d;
  logic [CW-1:0]    x_q,           x_d;
  logic [CW-1:0]    y_q,           y_d;
  logic             line_start_q,  line_start_d;
  logic             frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  logic tick;
  logic h_last;
  logic v_last;
  logic h_in_sync;
  logic v_in_sync;

  // ---------------------------------------------------------------------------
  // Tick and counter next-state
  // ---------------------------------------------------------------------------
  // The tick is taken from the divider *before* it advances, so the very
  // first enabled cycle after reset is a tick for pixel (0,0).
  always_comb begin
    tick   = vga.en && (div_q == '0);
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
  end

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;

    // en=0 freezes the divider too, so a pause neither loses nor adds a tick.
    if (vga.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: one decode of the current counters, registered together.
  // ---------------------------------------------------------------------------
  always_comb begin
    h_in_sync = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END);
    v_in_sync = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END);

    // Strobes are single-cycle and only ever high on a captured tick.
    p_tick_d      = tick;
    line_start_d  = tick && (h_cnt_q == '0);
    frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);

    // Levels hold between ticks (including while en=0).
    x_d     = x_q;
    y_d     = y_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      x_d     = h_cnt_q;
      y_d     = v_cnt_q;
      de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hsync_d = h_in_sync ? HS_ON : ~HS_ON;
      vsync_d = v_in_sync ? VS_ON : ~VS_ON;
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts in the same edge that raises frame_start, so the first frame
    // after reset already reads 1.
    frame_cnt_d = frame_start_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for every flop so all registers sample
      // the same pre-edge values regardless of statement order.
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      p_tick_q      <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      p_tick_q      <= p_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Interface drive
  // ---------------------------------------------------------------------------
  assign vga.p_tick      = p_tick_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign vga.frame_cnt   = frame_cnt_q;
`endif

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Two instances share one clock:
//     dut_d  default 640x480 geometry, CLK_DIV=4, active-low syncs
//     dut_s  small geometry H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, active-high syncs
//   Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_d;
  logic reset_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10), .FRAME_W(16)) if_d ();
  vga_timing_if #(.CW(4),  .FRAME_W(2))  if_s ();

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
    .CLK_DIV(4), .HSYNC_POL(0), .VSYNC_POL(0), .CW(10), .FRAME_W(16)
  ) dut_d (
    .clk   (clk),
    .reset (reset_d),
    .vga   (if_d.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1), .VSYNC_POL(1), .CW(4), .FRAME_W(2)
  ) dut_s (
    .clk   (clk),
    .reset (reset_s),
    .vga   (if_s.master)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_d = 1'b1;
    reset_s = 1'b1;
    if_d.en = 1'b1;
    if_s.en = 1'b0;
    repeat (5) @(negedge clk);

    checks++;
    if (if_d.de !== 1'b0) begin
      errors++; $display("FAIL reset_de got %b want 0", if_d.de);
    end
    checks++;
    if (if_d.x !== 10'd0 || if_d.y !== 10'd0) begin
      errors++; $display("FAIL reset_xy got x=%0d y=%0d want 0,0", if_d.x, if_d.y);
    end
    checks++;
    if (if_d.hsync !== 1'b1 || if_d.vsync !== 1'b1) begin
      errors++; $display("FAIL reset_sync got hs=%b vs=%b want 1,1", if_d.hsync, if_d.vsync);
    end
    checks++;
    if ({if_d.p_tick, if_d.line_start, if_d.frame_start} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b%b%b want 000",
                         if_d.p_tick, if_d.line_start, if_d.frame_start);
    end

    reset_d = 1'b0;
    reset_s = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_d.p_tick, if_d.line_start, if_d.frame_start, if_d.de} !== 4'b1111) begin
      errors++; $display("FAIL first_tick_strobes got pt/ls/fs/de=%b%b%b%b want 1111",
                         if_d.p_tick, if_d.line_start, if_d.frame_start, if_d.de);
    end
    checks++;
    if (if_d.x !== 10'd0 || if_d.y !== 10'd0) begin
      errors++; $display("FAIL first_tick_xy got x=%0d y=%0d want 0,0", if_d.x, if_d.y);
    end
    @(negedge clk);
    checks++;
    if ({if_d.p_tick, if_d.line_start, if_d.frame_start} !== 3'b000) begin
      errors++; $display("FAIL strobe_width got %b%b%b want 000",
                         if_d.p_tick, if_d.line_start, if_d.frame_start);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Entry: one clk after the (0,0) tick of dut_d. Walks the whole first line.
  task automatic test_line_timing();
    int   cyc      = 1;
    int   since    = 1;
    int   ticks    = 1;
    int   hs_ticks = 0;
    int   hs_first = -1;
    int   hs_last  = -1;
    int   gap_bad  = 0;
    int   glitch   = 0;
    bit   found    = 1'b0;
    logic prev_hs;

    prev_hs = if_d.hsync;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      since++;
      if (!if_d.p_tick) begin
        if (if_d.line_start || if_d.frame_start || if_d.hsync !== prev_hs) glitch++;
      end else begin
        if (since != 4) gap_bad++;
        since = 0;
        if (if_d.line_start) begin
          found = 1'b1;
          break;
        end
        ticks++;
        if (if_d.hsync === 1'b0) begin
          hs_ticks++;
          if (hs_first < 0) hs_first = int'(if_d.x);
          hs_last = int'(if_d.x);
        end
      end
      prev_hs = if_d.hsync;
    end

    checks++;
    if (!found) begin
      errors++; $display("FAIL line_start_timeout got none in %0d clk want one", cyc);
    end
    checks++;
    if (cyc != 3200) begin
      errors++; $display("FAIL line_period_clk got %0d want 3200", cyc);
    end
    checks++;
    if (ticks != 800) begin
      errors++; $display("FAIL line_ticks got %0d want 800", ticks);
    end
    checks++;
    if (hs_ticks != 96 || hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL hsync_window got n=%0d first=%0d last=%0d want 96,656,751",
                         hs_ticks, hs_first, hs_last);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL tick_spacing got %0d bad gaps want 0", gap_bad);
    end
    checks++;
    if (glitch != 0) begin
      errors++; $display("FAIL off_tick_change got %0d events want 0", glitch);
    end
    checks++;
    if (if_d.x !== 10'd0 || if_d.y !== 10'd1 || if_d.frame_start !== 1'b0) begin
      errors++; $display("FAIL second_line got x=%0d y=%0d fs=%b want 0,1,0",
                         if_d.x, if_d.y, if_d.frame_start);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Freeze dut_d for 37 clk right after the x=300 tick of line 1.
  task automatic test_en_pause();
    int cyc      = 0;
    int total    = 0;
    int hold_bad = 0;
    bit found    = 1'b0;

    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (if_d.p_tick && if_d.x == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL pause_seek_timeout got no x=300 in %0d clk want one", cyc);
      return;
    end

    if_d.en = 1'b0;
    repeat (37) begin
      @(negedge clk);
      total++;
      if (if_d.p_tick !== 1'b0 || if_d.line_start !== 1'b0 || if_d.x !== 10'd300 ||
          if_d.y !== 10'd1 || if_d.de !== 1'b1 || if_d.hsync !== 1'b1) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL pause_hold got %0d bad cycles want 0", hold_bad);
    end

    if_d.en = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      total++;
      if (if_d.p_tick) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || total != 41 || if_d.x !== 10'd301) begin
      errors++; $display("FAIL resume_tick got found=%0d gap=%0d x=%0d want 1,41,301",
                         found, total, if_d.x);
    end

    cyc = 0;
    found = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (if_d.line_start) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || total != 2037 || if_d.y !== 10'd2) begin
      errors++; $display("FAIL pause_line_period got found=%0d clk=%0d y=%0d want 1,2037,2",
                         found, total, if_d.y);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_line();
    int cyc   = 0;
    bit found = 1'b0;

    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (if_d.p_tick && if_d.x == 10'd500) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || if_d.de !== 1'b1) begin
      errors++; $display("FAIL midreset_seek got found=%0d de=%b want 1,1", found, if_d.de);
    end

    #2 reset_d = 1'b1;
    #1;
    checks++;
    if (if_d.x !== 10'd0 || if_d.y !== 10'd0 || if_d.de !== 1'b0 ||
        if_d.hsync !== 1'b1 || if_d.vsync !== 1'b1 || if_d.p_tick !== 1'b0) begin
      errors++; $display("FAIL midreset_clear got x=%0d y=%0d de=%b hs=%b vs=%b pt=%b want 0,0,0,1,1,0",
                         if_d.x, if_d.y, if_d.de, if_d.hsync, if_d.vsync, if_d.p_tick);
    end
    @(negedge clk);
    reset_d = 1'b0;
    @(negedge clk);
    checks++;
    if (if_d.frame_start !== 1'b1 || if_d.x !== 10'd0 || if_d.y !== 10'd0) begin
      errors++; $display("FAIL midreset_restart got fs=%b x=%0d y=%0d want 1,0,0",
                         if_d.frame_start, if_d.x, if_d.y);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Small geometry: totals 14 x 7, one tick per clk, active-high syncs.
  task automatic test_small_mode();
    logic [13:0] exp_v;
    logic [13:0] got_v;
    int ex, ey, fs_count, last_fs, spacing_bad, de_frame0;

    if_s.en = 1'b1;
    repeat (81) @(negedge clk);   // pixel index 80 = (10,5)
    checks++;
    if (if_s.x !== 4'd10 || if_s.y !== 4'd5 || if_s.hsync !== 1'b1 || if_s.vsync !== 1'b1) begin
      errors++; $display("FAIL small_presync got x=%0d y=%0d hs=%b vs=%b want 10,5,1,1",
                         if_s.x, if_s.y, if_s.hsync, if_s.vsync);
    end

    #2 reset_s = 1'b1;
    #1;
    checks++;
    if (if_s.x !== 4'd0 || if_s.y !== 4'd0 || if_s.hsync !== 1'b0 || if_s.vsync !== 1'b0 ||
        if_s.de !== 1'b0 || if_s.p_tick !== 1'b0) begin
      errors++; $display("FAIL small_reset got x=%0d y=%0d hs=%b vs=%b de=%b pt=%b want 0,0,0,0,0,0",
                         if_s.x, if_s.y, if_s.hsync, if_s.vsync, if_s.de, if_s.p_tick);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (if_s.frame_cnt !== 2'd0) begin
      errors++; $display("FAIL frame_cnt_reset got %0d want 0", if_s.frame_cnt);
    end
`endif
    @(negedge clk);
    reset_s = 1'b0;

    fs_count    = 0;
    last_fs     = -98;
    spacing_bad = 0;
    de_frame0   = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      ex = k % 14;
      ey = (k / 14) % 7;
      exp_v = {1'b1, (ex == 0), (ex == 0 && ey == 0), (ex < 8 && ey < 4),
               (ex >= 10 && ex <= 11), (ey == 5), 4'(ex), 4'(ey)};
      got_v = {if_s.p_tick, if_s.line_start, if_s.frame_start, if_s.de,
               if_s.hsync, if_s.vsync, if_s.x, if_s.y};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL small_pixel k=%0d got %b want %b (pt ls fs de hs vs x y)",
                           k, got_v, exp_v);
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++;
      if (if_s.frame_cnt !== 2'(((k / 98) + 1) % 4)) begin
        errors++; $display("FAIL frame_cnt k=%0d got %0d want %0d",
                           k, if_s.frame_cnt, ((k / 98) + 1) % 4);
      end
`endif
      if (if_s.frame_start) begin
        fs_count++;
        if (k - last_fs != 98) spacing_bad++;
        last_fs = k;
      end
      if (k < 98 && if_s.de) de_frame0++;
    end
    checks++;
    if (fs_count != 4 || spacing_bad != 0) begin
      errors++; $display("FAIL small_frame_period got pulses=%0d bad=%0d want 4,0",
                         fs_count, spacing_bad);
    end
    checks++;
    if (de_frame0 != 32) begin
      errors++; $display("FAIL small_de_count got %0d want 32", de_frame0);
    end

    // Last sample was pixel 299 = (5,0); freeze for 3 clk with CLK_DIV=1.
    if_s.en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (if_s.p_tick !== 1'b0 || if_s.x !== 4'd5) begin
        errors++; $display("FAIL small_pause got pt=%b x=%0d want 0,5", if_s.p_tick, if_s.x);
      end
    end
    if_s.en = 1'b1;
    @(negedge clk);
    checks++;
    if (if_s.p_tick !== 1'b1 || if_s.x !== 4'd6 || if_s.y !== 4'd0) begin
      errors++; $display("FAIL small_resume got pt=%b x=%0d y=%0d want 1,6,0",
                         if_s.p_tick, if_s.x, if_s.y);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_line_timing();
    test_en_pause();
    test_reset_mid_line();
    test_small_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_vga_timing_gen
